// File: rtl/axis_rr_packet_arbiter.sv
// rtl/axis_rr_packet_arbiter.sv - round-robin AXI-Stream packet arbiter with packet lock and registered output
module axis_rr_packet_arbiter #(
  parameter  int NUM_CH = 4,
  parameter  int DATA_W = 8,
  localparam int ID_W   = $clog2(NUM_CH)
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [NUM_CH-1:0]        s_axis_tvalid,
  output logic [NUM_CH-1:0]        s_axis_tready,
  input  logic [NUM_CH*DATA_W-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]        s_axis_tlast,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic [DATA_W-1:0]        m_axis_tdata,
  output logic                     m_axis_tlast,
  output logic [ID_W-1:0]          m_axis_tid,
  output logic                     busy
);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   grant;
  logic [ID_W-1:0]   pick;
  logic [ID_W-1:0]   ptr_after_grant;
  logic              any_req;
  logic              out_ready;
  logic              in_fire;
  logic              in_last;
  logic [DATA_W-1:0] in_data;

  // Channel index base+off, wrapped explicitly so non-power-of-2 NUM_CH works.
  function automatic logic [ID_W-1:0] add_wrap(input logic [ID_W-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_CH) s = s - NUM_CH;
    return ID_W'(s);
  endfunction

  // Walk the search order backwards so the earliest requester wins.
  always_comb begin
    pick    = '0;
    any_req = |s_axis_tvalid;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (s_axis_tvalid[add_wrap(rr_ptr, k)]) pick = add_wrap(rr_ptr, k);
    end
  end

  assign out_ready       = !m_axis_tvalid || m_axis_tready;
  assign in_data         = s_axis_tdata[grant*DATA_W +: DATA_W];
  assign in_last         = s_axis_tlast[grant];
  assign in_fire         = (state == LOCK) && s_axis_tvalid[grant] && out_ready;
  assign ptr_after_grant = (grant == ID_W'(NUM_CH - 1)) ? '0 : grant + ID_W'(1);

  always_comb begin
    s_axis_tready = '0;
    if (state == LOCK) s_axis_tready[grant] = out_ready;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      grant         <= '0;
      busy          <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tid    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= pick;
            state <= LOCK;
            busy  <= 1'b1;
          end
        end
        LOCK: begin
          if (in_fire && in_last) begin
            state  <= IDLE;
            busy   <= 1'b0;
            rr_ptr <= ptr_after_grant;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      if (in_fire) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= in_data;
        m_axis_tlast  <= in_last;
        m_axis_tid    <= grant;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/axis_rr_packet_arbiter.md
# axis_rr_packet_arbiter

N-input AXI-Stream packet arbiter with round-robin fairness, packet locking and a registered output stage. It merges NUM_CH independent byte- or word-streams onto one master stream without interleaving packets. Source channels are back-pressured correctly, with no always-ready inputs and no dropped beats. It sits between per-source stream producers and a single shared downstream consumer such as a DMA, FIFO or serializer.

## Interface
- NUM_CH, 4: number of slave input channels; legal range 2..16.
- DATA_W, 8: tdata width per channel, in bits.
- ID_W, derived as $clog2(NUM_CH): width of m_axis_tid. Not user-set.

- aclk  in  1  single clock; all logic rising-edge.
- areset  in  1  asynchronous, active-high reset.
- s_axis_tvalid  in  NUM_CH  per-channel valid; bit i is channel i.
- s_axis_tready  out  NUM_CH  per-channel ready.
- s_axis_tdata  in  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- s_axis_tlast  in  NUM_CH  per-channel end-of-packet.
- m_axis_tvalid  out  1  registered output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  DATA_W  registered output data.
- m_axis_tlast  out  1  registered output end-of-packet.
- m_axis_tid  out  ID_W  index of the source channel of the current output beat.
- busy  out  1  high while a packet is locked (state LOCK).

## Operation
- FSM states:
  - IDLE: no grant held.
  - LOCK: channel `grant` owns the output until its tlast beat is transferred.
- Round-robin pointer `rr_ptr` (ID_W bits) gives the highest-priority channel.
  - Search order is rr_ptr, rr_ptr+1, …, wrapping modulo NUM_CH.
  - Reset value is 0.
- IDLE behaviour:
  - All s_axis_tready are 0.
  - If any s_axis_tvalid is set, `grant` <= first set channel in search order and state <= LOCK.
  - Otherwise remain in IDLE.
- LOCK behaviour:
  - s_axis_tready[grant] = out_ready; all other readies are 0.
  - out_ready = !m_axis_tvalid || m_axis_tready.
  - An input beat is accepted when s_axis_tvalid[grant] && s_axis_tready[grant]. The output register loads tdata, tlast, tid=grant and sets m_axis_tvalid.
  - If the accepted beat has tlast=1: state <= IDLE and rr_ptr <= (grant+1) mod NUM_CH. For non-power-of-2 NUM_CH, wrap explicitly.
  - A granted channel that deasserts tvalid mid-packet keeps the grant. There is no timeout.
- Output register:
  - Clears m_axis_tvalid when m_axis_tready=1 and no new beat loads in the same cycle.
  - Holds tdata, tlast and tid stable while m_axis_tvalid && !m_axis_tready (AXI-Stream rule).
- Packets from different channels never interleave on the master. Beats within a packet keep their order.
- A packet of length 1 (tlast on its first beat) is legal.
- Simultaneous requests in IDLE are resolved purely by rr_ptr. The requester set is sampled in the IDLE cycle only.
- In IDLE, tdata and tlast on the inputs are ignored.

## Timing
- Reset (areset=1, asynchronous):
  - state=IDLE, rr_ptr=0, grant=0.
  - m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, m_axis_tid=0, busy=0.
  - s_axis_tready=0.
- Reset mid-packet discards the locked packet and any beat held in the output register. The first post-reset arbitration starts at channel 0.
- Arbitration costs 1 cycle per packet: the IDLE cycle, in which no input beat is accepted.
- Latency: an input handshake at edge k gives m_axis_tvalid=1 with that beat from edge k onward (visible in cycle k+1).
- Throughput:
  - Within a packet, 1 beat/cycle while m_axis_tready=1.
  - Between packets, at most 1 bubble cycle.
  - For back-to-back packets of L beats, the master carries L beats per L+1 cycles.
- s_axis_tready[grant] depends combinationally on m_axis_tready. This is the only combinational in-to-out path.

## Test plan
- Single channel, NUM_CH=4, DATA_W=8: ch2 sends 3-beat packet 0x11,0x22,0x33 with tlast on 0x33, m_axis_tready=1 -> master shows the same 3 beats with tid=2 and tlast on beat 3; busy drops the cycle after the handshake of 0x33; rr_ptr=3.
- Fairness after reset: all 4 channels continuously valid with 2-beat packets -> packet grant order is 0,1,2,3,0,…, with exactly one idle master cycle between packets.
- Backpressure: m_axis_tready held 0 for 5 cycles mid-packet -> m_axis_tdata, tlast and tid are stable for all 5 cycles; s_axis_tready[grant]=0 while the register is full; no beat is lost or duplicated.
- Valid gap in a locked packet: ch1 deasserts tvalid for 3 cycles mid-packet while ch0 is valid -> the ch1 grant is held, no ch0 beat appears until the ch1 tlast beat, then ch2/ch3/ch0 are searched from rr_ptr=2.
- 1-beat packets and wrap: only ch3 and ch0 valid, 1-beat packets each -> order alternates 3,0,3,0 once rr_ptr wraps from 3 to 0; the NUM_CH=3 build also wraps 2->0 correctly.
- Async reset mid-packet: areset pulsed for 1 cycle during beat 2 of a 4-beat packet -> all outputs are 0 immediately, without waiting for a clock edge; the next packet grant goes to the lowest valid index.
